// File: rtl/hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// hazard_ctrl_pkg
//   Shared definitions for the hazard/stall controller:
//     - hz_state_e   : controller state encoding (RUN / STALL)
//     - REG_ZERO     : architectural zero register index (never a hazard)
//     - LUS_MIN/MAX  : legal range of the load-use stall length parameter
//     - is_load_use(): load-use RAW hazard detection against the EX load
// ----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         LUS_MIN  = 1;
  localparam int         LUS_MAX  = 3;

  // A load in EX writing a non-zero register that the ID instruction reads.
  // rt only counts when the ID instruction actually reads it.
  function automatic logic is_load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = (ex_rt == id_rs);
    rt_hit = id_uses_rt & (ex_rt == id_rt);
    return ex_mem_read & (ex_rt != REG_ZERO) & (rs_hit | rt_hit);
  endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
//   Saturating up-counter used for the controller's performance counters.
//   Ports:
//     clk     in  1      rising-edge clock
//     startin in  1      asynchronous reset, active-high (count -> 0)
//     inc     in  1      increment request (ignored once at all-ones)
//     clr     in  1      synchronous clear, wins over inc
//     cnt     out CNT_W  current count
// ----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             startin,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next count: clear first, then a non-wrapping increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard/stall controller. Inserts LOAD_USE_STALL bubbles on a
//   load-use hazard, squashes IF/ID, ID/EX and EX/MEM on a taken branch
//   resolved in MEM, and freezes the pipe while data memory is busy.
//   Priority: startin > branch > dmem_busy > load-use/STALL > normal.
//   Ports:
//     clk, startin                  clock, async active-high reset
//     ID_rs, ID_rt, ID_uses_rt      sources of the instruction in ID
//     EX_mem_read, EX_rt            load in EX and its destination
//     MEM_branch_taken              taken branch resolved in MEM
//     dmem_busy                     data memory not ready
//     clr_cnt                       synchronous clear of both counters
//     pc_write, IF_ID_write         front-end load enables
//     IF_ID_flush, ID_EX_bubble,
//     EX_MEM_flush                  pipeline register clears
//     pipe_hold                     hold every pipeline register
//     stall_cycles, flush_events    saturating performance counters
//   Control outputs are combinational from state and inputs so they act in
//   the same cycle the hazard is seen.
// ----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             startin,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rt,
  input  logic             EX_mem_read,
  input  logic [4:0]       EX_rt,
  input  logic             MEM_branch_taken,
  input  logic             dmem_busy,
  input  logic             clr_cnt,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_flush,
  output logic             pipe_hold,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  if ((LOAD_USE_STALL < LUS_MIN) || (LOAD_USE_STALL > LUS_MAX)) begin : g_bad_lus
    $error("hazard_ctrl: LOAD_USE_STALL must be in 1..3");
  end

  // Bubbles still owed after the first one of a load-use stall.
  localparam logic [1:0] REM_INIT = 2'(LOAD_USE_STALL - 1);

  hz_state_e  state_d;
  hz_state_e  state_q;
  logic [1:0] rem_d;
  logic [1:0] rem_q;
  logic       load_use_s;
  logic       stall_inc_s;
  logic       flush_inc_s;

  assign load_use_s = is_load_use(EX_mem_read, EX_rt, ID_rs, ID_rt, ID_uses_rt);

  // Next state, stall countdown, counter increments and control outputs.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    stall_inc_s  = 1'b0;
    flush_inc_s  = 1'b0;
    pc_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_MEM_flush = 1'b0;
    pipe_hold    = 1'b0;

    if (startin) begin
      // Reset asserted: nothing advances, every stage is cleared.
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      EX_MEM_flush = 1'b1;
      state_d      = ST_RUN;
      rem_d        = 2'd0;
    end else if (MEM_branch_taken) begin
      // Squash the three younger stages; any pending stall belongs to a
      // wrong-path instruction and is dropped.
      IF_ID_flush  = 1'b1;
      ID_EX_bubble = 1'b1;
      EX_MEM_flush = 1'b1;
      flush_inc_s  = 1'b1;
      state_d      = ST_RUN;
      rem_d        = 2'd0;
    end else if (dmem_busy) begin
      // Whole-pipe freeze: state and countdown stay put.
      pc_write     = 1'b0;
      IF_ID_write  = 1'b0;
      pipe_hold    = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use_s) begin
            pc_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
            stall_inc_s  = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              state_d = ST_STALL;
              rem_d   = REM_INIT;
            end else begin
              state_d = ST_RUN;
              rem_d   = 2'd0;
            end
          end else begin
            state_d = ST_RUN;
            rem_d   = rem_q;
          end
        end
        ST_STALL: begin
          // load_use is ignored here: the countdown alone ends the stall.
          pc_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          stall_inc_s  = 1'b1;
          if (rem_q <= 2'd1) begin
            state_d = ST_RUN;
            rem_d   = 2'd0;
          end else begin
            state_d = ST_STALL;
            rem_d   = rem_q - 2'd1;
          end
        end
        default: begin
          state_d = ST_RUN;
          rem_d   = 2'd0;
        end
      endcase
    end
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      state_q <= ST_RUN;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .startin (startin),
    .inc     (stall_inc_s),
    .clr     (clr_cnt),
    .cnt     (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .startin (startin),
    .inc     (flush_inc_s),
    .clr     (clr_cnt),
    .cnt     (flush_events)
  );

endmodule
